// File: rtl/shift_rows_serial.sv
// rtl/shift_rows_serial.sv - byte-serial forward AES ShiftRows; SHIFT_ROWS_PINGPONG_EN selects two-bank streaming
// Input and output bytes are column-major (i = row + 4*col); row r is rotated left by r.
module shift_rows_serial (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  // Source index of output byte k: same row, column advanced by the row number.
  function automatic logic [3:0] perm(input logic [3:0] k);
    logic [1:0] col;
    col = k[3:2] + k[1:0];
    return {col, k[1:0]};
  endfunction

  logic [3:0] wcnt;
  logic [3:0] rcnt;
  logic       wr_fire;
  logic       rd_fire;

  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = out_valid && out_ready;
  assign out_last = out_valid && (rcnt == 4'd15);

`ifdef SHIFT_ROWS_PINGPONG_EN

  logic [7:0] bank [0:1][0:15];
  logic [1:0] full;
  logic       wsel;
  logic       rsel;

  assign in_ready  = !full[wsel];
  assign out_valid = full[rsel];
  assign out_byte  = bank[rsel][perm(rcnt)];

  // Write and read never touch the same bank in one cycle: one needs it empty, the other full.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wcnt <= 4'd0;
      rcnt <= 4'd0;
      wsel <= 1'b0;
      rsel <= 1'b0;
      full <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 16; i++) begin
          bank[b][i] <= 8'h00;
        end
      end
    end else if (clear) begin
      wcnt <= 4'd0;
      rcnt <= 4'd0;
      wsel <= 1'b0;
      rsel <= 1'b0;
      full <= 2'b00;
    end else begin
      if (wr_fire) begin
        bank[wsel][wcnt] <= in_byte;
        wcnt             <= wcnt + 4'd1;
        if (wcnt == 4'd15) begin
          full[wsel] <= 1'b1;
          wsel       <= ~wsel;
        end
      end
      if (rd_fire) begin
        rcnt <= rcnt + 4'd1;
        if (rcnt == 4'd15) begin
          full[rsel] <= 1'b0;
          rsel       <= ~rsel;
        end
      end
    end
  end

`else

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [7:0] bank [0:15];
  logic [0:0] state;

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign out_byte  = bank[perm(rcnt)];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wcnt  <= 4'd0;
      rcnt  <= 4'd0;
      state <= FILL;
      for (int i = 0; i < 16; i++) begin
        bank[i] <= 8'h00;
      end
    end else if (clear) begin
      wcnt  <= 4'd0;
      rcnt  <= 4'd0;
      state <= FILL;
    end else begin
      if (wr_fire) begin
        bank[wcnt] <= in_byte;
        wcnt       <= wcnt + 4'd1;
        if (wcnt == 4'd15) begin
          state <= DRAIN;
        end
      end
      if (rd_fire) begin
        rcnt <= rcnt + 4'd1;
        if (rcnt == 4'd15) begin
          state <= FILL;
        end
      end
    end
  end

`endif

endmodule

// File: tb/tb_shift_rows_serial.sv
// tb/tb_shift_rows_serial.sv - directed self-checking bench for shift_rows_serial
module tb_shift_rows_serial;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;

  int n_checks = 0;
  int n_fail = 0;

`ifdef SHIFT_ROWS_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic [7:0] first_seq [0:15] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                   8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};

  shift_rows_serial dut (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (clear),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Expected output byte k of a block whose input bytes are base+0..base+15.
  function automatic logic [7:0] exp_byte(input int base, input int k);
    int r, c;
    r = k % 4;
    c = k / 4;
    return 8'(base + r + 4 * ((c + r) % 4));
  endfunction

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  // Bytes 0x00..0x0F in cycles 0-15 with out_ready high; checks the hand-computed sequence.
  task automatic first_block(input string tag);
    out_ready = 1'b1;
    for (int t = 0; t < 33; t++) begin
      in_valid = (t < 16);
      in_byte = (t < 16) ? 8'(t) : 8'h00;
      if (t < 16) begin
        chk({tag, "_fill_valid"}, out_valid, 1'b0);
        chk({tag, "_fill_ready"}, in_ready, 1'b1);
      end else if (t < 32) begin
        chk({tag, "_out_valid"}, out_valid, 1'b1);
        chk({tag, "_out_byte"}, out_byte, first_seq[t-16]);
        chk({tag, "_out_last"}, out_last, (t == 31));
        chk({tag, "_drain_ready"}, in_ready, PP);
      end else begin
        chk({tag, "_after_valid"}, out_valid, 1'b0);
      end
      cycle();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int n_in, n_out, limit, total, t_max;
    logic [7:0] held;

    // Reset values
    resetn = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_byte", out_byte, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);
    do_reset();

    // Single block, latency and hand-computed order
    first_block("blk1");

    // Three blocks back to back
    do_reset();
    out_ready = 1'b1;
    n_in = 0;
    n_out = 0;
    t_max = PP ? 64 : 96;
    for (int t = 0; t < t_max; t++) begin
      in_valid = (n_in < 48);
      in_byte = 8'(n_in);
      if (PP) begin
        chk("b2b_in_ready", in_ready, 1'b1);
        chk("b2b_out_valid", out_valid, (t >= 16));
      end else begin
        chk("b2b_in_ready", in_ready, ((t / 16) % 2 == 0));
        chk("b2b_out_valid", out_valid, ((t / 16) % 2 == 1));
      end
      if (out_valid) begin
        chk("b2b_out_byte", out_byte, exp_byte((n_out / 16) * 16, n_out % 16));
        chk("b2b_out_last", out_last, (n_out % 16 == 15));
      end
      if (in_valid && in_ready) n_in++;
      if (out_valid && out_ready) n_out++;
      cycle();
    end
    chk("b2b_in_count", n_in, 48);
    chk("b2b_out_count", n_out, 48);

    // Back-pressure: fill until in_ready drops, extra bytes ignored, then stalled drain
    do_reset();
    in_valid = 1'b0;
    limit = PP ? 32 : 16;
    n_in = 0;
    for (int t = 0; t < 45; t++) begin
      in_valid = 1'b1;
      in_byte = (n_in < limit) ? 8'(8'h40 + n_in) : 8'hEE;
      chk("bp_in_ready", in_ready, (n_in < limit));
      if (t >= 16) begin
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_byte", out_byte, 8'h40);
      end
      if (in_valid && in_ready) n_in++;
      cycle();
    end
    chk("bp_accepted", n_in, limit);
    in_valid = 1'b0;
    n_out = 0;
    total = limit;
    held = 8'h00;
    for (int t = 0; t < 200 && n_out < total; t++) begin
      out_ready = (t % 3 != 0);
      chk("bp_drain_valid", out_valid, 1'b1);
      chk("bp_drain_byte", out_byte, exp_byte(8'h40 + (n_out / 16) * 16, n_out % 16));
      chk("bp_drain_last", out_last, (n_out % 16 == 15));
      if (t > 0 && (t - 1) % 3 == 0) chk("bp_stall_stable", out_byte, held);
      held = out_byte;
      if (out_valid && out_ready) n_out++;
      cycle();
    end
    chk("bp_drained", n_out, total);
    chk("bp_empty_valid", out_valid, 1'b0);
    chk("bp_empty_ready", in_ready, 1'b1);

    // clear after 7 bytes discards the partial block
    do_reset();
    out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      in_valid = 1'b1;
      in_byte = 8'(8'hA0 + t);
      cycle();
    end
    clear = 1'b1;
    in_byte = 8'hFF;
    cycle();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b1);
    first_block("clr");

    // Asynchronous reset in the middle of a drain
    do_reset();
    out_ready = 1'b1;
    n_out = 0;
    for (int t = 0; t < 21; t++) begin
      in_valid = (t < 16);
      in_byte = 8'(8'h30 + t);
      if (out_valid && out_ready) n_out++;
      cycle();
    end
    in_valid = 1'b0;
    chk("arst_pre_valid", out_valid, 1'b1);
    chk("arst_pre_byte", out_byte, exp_byte(8'h30, 5));
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_last", out_last, 1'b0);
    chk("arst_out_byte", out_byte, 8'h00);
    chk("arst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    first_block("arst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
